// File: rtl/pool_pkg.sv
// Shared types and helpers for the multi-channel 2x2 pooling block.
//   state_e     : frame-level FSM states (IDLE waits for start, RUN consumes pixels)
//   pool_mode_e : pooling operator selected at frame start
//   pool_max2   : signed maximum of two samples, evaluated at a fixed wide
//                 width so any lane width can use it after sign extension
package pool_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Callers sign-extend into this width and slice the result back down.
  localparam int MAX_W = 64;

  function automatic logic signed [MAX_W-1:0] pool_max2(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the 2x2 / stride-2 pooling datapath.
// Holds the even-column pixel, the per-column pair buffer filled on even rows,
// and the final combine (max or floor-average) on odd rows.
// Optional feature macro: POOL_RELU_EN clamps negative pooled values to zero.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_beat      : a pixel is accepted this cycle
//   i_x_odd     : accepted pixel is in an odd column
//   i_row_odd   : accepted pixel is in an odd row
//   i_mode      : pooling operator latched for the frame
//   i_idx       : pair-buffer column index (x/2)
//   i_pixel     : this lane's signed sample
//   o_result    : registered pooled sample, holds between results
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W    = 22,
  parameter int IMG_WIDTH = 32,
  parameter int IDX_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_beat,
  input  logic                     i_x_odd,
  input  logic                     i_row_odd,
  input  pool_mode_e               i_mode,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic signed [DATA_W-1:0] i_pixel,
  output logic signed [DATA_W-1:0] o_result
);

  localparam int PAIRS = IMG_WIDTH / 2;

  logic signed [DATA_W-1:0] r_pixel_d1;
  logic signed [DATA_W-1:0] r_result;
  logic signed [DATA_W:0]   r_pair_buf [PAIRS];

  logic signed [MAX_W-1:0]  w_max_pair;
  logic signed [MAX_W-1:0]  w_max4;
  logic signed [DATA_W:0]   w_pair_new;
  logic signed [DATA_W+1:0] w_sum4;
  logic signed [DATA_W+1:0] w_avg;
  logic signed [DATA_W-1:0] w_pool;
  logic signed [DATA_W-1:0] w_out;
  logic                     w_unused_bits;

  // Horizontal pair result (stored on even rows) and the full 2x2 result
  // (produced on odd rows). In avg mode the buffer keeps the raw pair sum so
  // the final shift sees the exact 4-sample total and floors correctly.
  always_comb begin
    w_max_pair = pool_max2(MAX_W'(r_pixel_d1), MAX_W'(i_pixel));
    w_max4     = pool_max2(MAX_W'(r_pair_buf[i_idx]), w_max_pair);
    w_sum4     = (DATA_W+2)'(r_pair_buf[i_idx]) + (DATA_W+2)'(r_pixel_d1)
               + (DATA_W+2)'(i_pixel);
    w_avg      = w_sum4 >>> 2;
    if (i_mode == POOL_AVG) begin
      w_pair_new = (DATA_W+1)'(r_pixel_d1) + (DATA_W+1)'(i_pixel);
      w_pool     = w_avg[DATA_W-1:0];
    end else begin
      w_pair_new = w_max_pair[DATA_W:0];
      w_pool     = w_max4[DATA_W-1:0];
    end
`ifdef POOL_RELU_EN
    w_out = w_pool[DATA_W-1] ? '0 : w_pool;
`else
    w_out = w_pool;
`endif
  end

  // Upper bits of the wide max and of the shifted sum are only sign copies.
  assign w_unused_bits = ^{w_max_pair[MAX_W-1:DATA_W+1], w_max4[MAX_W-1:DATA_W],
                           w_avg[DATA_W+1:DATA_W]};

  // Even columns capture the left pixel of the pair; odd rows at odd columns
  // register the pooled value, which then holds until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel_d1 <= '0;
      r_result   <= '0;
    end else if (i_beat) begin
      if (!i_x_odd) begin
        r_pixel_d1 <= i_pixel;
      end else if (i_row_odd) begin
        r_result <= w_out;
      end
    end
  end

  // Pair buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_beat && i_x_odd && !i_row_odd) begin
      r_pair_buf[i_idx] <= w_pair_new;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/pool2d_multi_ch.sv
// Streaming 2x2 / stride-2 pooling over a raster frame with CHANNELS lanes in
// parallel; max or floor-average selected per frame.
// Optional feature macro: POOL_RELU_EN (post-pool ReLU inside each lane).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start_signal  : frame start request, honoured only in IDLE
//   mode_avg      : 0 = max, 1 = average, latched on accepted start
//   pixel_valid   : pixel_in carries a sample this cycle
//   pixel_in      : CHANNELS packed signed samples, raster order
//   result_out    : CHANNELS packed pooled samples
//   result_valid  : one-cycle pulse per pooled output
//   busy          : high while a frame is running
//   done_signal   : one-cycle pulse alongside the final result of a frame
module pool2d_multi_ch
  import pool_pkg::*;
#(
  parameter int DATA_W     = 22,
  parameter int CHANNELS   = 1,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_signal,
  input  logic                         mode_avg,
  input  logic                         pixel_valid,
  input  logic [CHANNELS*DATA_W-1:0]   pixel_in,
  output logic [CHANNELS*DATA_W-1:0]   result_out,
  output logic                         result_valid,
  output logic                         busy,
  output logic                         done_signal
);

  localparam int XW    = $clog2(IMG_WIDTH);
  localparam int YW    = $clog2(IMG_HEIGHT);
  localparam int PAIRS = IMG_WIDTH / 2;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
    $fatal(1, "pool2d_multi_ch: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
    $fatal(1, "pool2d_multi_ch: IMG_HEIGHT must be even and >= 2");
  end

  state_e            r_state;
  state_e            w_state_next;
  pool_mode_e        r_mode;
  logic [XW-1:0]     r_cnt_x;
  logic [YW-1:0]     r_cnt_y;
  logic              r_result_valid;
  logic              r_done;

  logic              w_start_ok;
  logic              w_beat;
  logic              w_last_x;
  logic              w_last_y;
  logic              w_frame_end;
  logic [IDX_W-1:0]  w_idx;

  // The cycle carrying done is already IDLE, but a start there must not begin
  // a new frame, hence the r_done qualifier.
  assign w_start_ok  = (r_state == IDLE) && start_signal && !r_done;
  assign w_beat      = (r_state == RUN) && pixel_valid;
  assign w_last_x    = (r_cnt_x == XW'(IMG_WIDTH - 1));
  assign w_last_y    = (r_cnt_y == YW'(IMG_HEIGHT - 1));
  assign w_frame_end = w_beat && w_last_x && w_last_y;
  assign w_idx       = IDX_W'(r_cnt_x >> 1);

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: leave RUN on the edge that accepts the last pixel so the FSM
  // is back in IDLE during the cycle that shows the final result.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_start_ok)  w_state_next = RUN;
      RUN:  if (w_frame_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Raster counters, operator latch and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_x        <= '0;
      r_cnt_y        <= '0;
      r_mode         <= POOL_MAX;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_result_valid <= w_beat && r_cnt_x[0] && r_cnt_y[0];
      r_done         <= w_frame_end;
      if (w_start_ok) begin
        r_cnt_x <= '0;
        r_cnt_y <= '0;
        r_mode  <= mode_avg ? POOL_AVG : POOL_MAX;
      end else if (w_beat) begin
        if (w_last_x) begin
          r_cnt_x <= '0;
          r_cnt_y <= w_last_y ? '0 : r_cnt_y + YW'(1);
        end else begin
          r_cnt_x <= r_cnt_x + XW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_lane #(
      .DATA_W    (DATA_W),
      .IMG_WIDTH (IMG_WIDTH),
      .IDX_W     (IDX_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_beat    (w_beat),
      .i_x_odd   (r_cnt_x[0]),
      .i_row_odd (r_cnt_y[0]),
      .i_mode    (r_mode),
      .i_idx     (w_idx),
      .i_pixel   (pixel_in[c*DATA_W +: DATA_W]),
      .o_result  (result_out[c*DATA_W +: DATA_W])
    );
  end

  assign result_valid = r_result_valid;
  assign busy         = (r_state == RUN);
  assign done_signal  = r_done;

endmodule

// File: tb/tb_pool2d_multi_ch.sv
// Scoreboard bench for pool2d_multi_ch: 4x4 frames, two 22-bit lanes.
// Stimulus pushes hand-computed expected results; a negedge monitor pops and
// compares whenever result_valid is seen.
module tb_pool2d_multi_ch;

  localparam int DW = 22;
  localparam int CH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_signal;
  logic               mode_avg;
  logic               pixel_valid;
  logic [CH*DW-1:0]   pixel_in;
  logic [CH*DW-1:0]   result_out;
  logic               result_valid;
  logic               busy;
  logic               done_signal;

  typedef struct {
    int l0;
    int l1;
    bit done;
  } exp_t;

  exp_t expQ[$];
  int   errCount   = 0;
  int   checkCount = 0;
  int   pix0[16];
  int   pix1[16];

  pool2d_multi_ch #(
    .DATA_W     (DW),
    .CHANNELS   (CH),
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .mode_avg     (mode_avg),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .result_out   (result_out),
    .result_valid (result_valid),
    .busy         (busy),
    .done_signal  (done_signal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkValue(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("lane0", int'($signed(result_out[DW-1:0])), e.l0);
    checkValue("lane1", int'($signed(result_out[2*DW-1:DW])), e.l1);
    checkValue("done_with_result", int'(done_signal), int'(e.done));
  endtask

  // Monitor: every result beat must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        if (expQ.size() == 0) begin
          errCount++;
          checkCount++;
          $display("[TB] FAIL unexpected_result: got %0d/%0d, expected none",
                   $signed(result_out[DW-1:0]), $signed(result_out[2*DW-1:DW]));
        end else begin
          checkOutput(expQ.pop_front());
        end
      end else if (done_signal) begin
        errCount++;
        checkCount++;
        $display("[TB] FAIL done_alone: got done=1 without result, expected 0");
      end
    end
  end

  task automatic pushFrame(input int e0[4], input int e1[4]);
    for (int k = 0; k < 4; k++) begin
      expQ.push_back('{l0: relu(e0[k]), l1: relu(e1[k]), done: (k == 3)});
    end
  endtask

  task automatic startFrame(input bit avg);
    start_signal = 1'b1;
    mode_avg     = avg;
    @(posedge clk); #1;
    start_signal = 1'b0;
    mode_avg     = ~avg;
    checkValue("busy_after_start", int'(busy), 1);
  endtask

  task automatic applyStimulus(input int nPix, input int gapMax, input bit midStart);
    for (int i = 0; i < nPix; i++) begin
      int gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      for (int g = 0; g < gaps; g++) begin
        pixel_valid = 1'b0;
        pixel_in    = {DW'($urandom), DW'($urandom)};
        @(posedge clk); #1;
      end
      pixel_valid  = 1'b1;
      pixel_in     = {DW'(pix1[i]), DW'(pix0[i])};
      start_signal = midStart && (i == 8);
      @(posedge clk); #1;
      pixel_valid  = 1'b0;
      start_signal = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkValue("queue_drained", expQ.size(), 0);
    checkValue("busy_idle", int'(busy), 0);
  endtask

  task automatic rampPixels();
    for (int i = 0; i < 16; i++) begin
      pix0[i] = i + 1;
      pix1[i] = -(i + 1);
    end
  endtask

  initial begin
    int maxE0[4] = '{6, 8, 14, 16};
    int maxE1[4] = '{-1, -3, -9, -11};
    int avgE0[4] = '{3, 5, 11, 13};
    int avgE1[4] = '{-4, -6, -12, -14};
    int altE0[4] = '{-2, -2, -2, -2};
    int altE1[4] = '{1, 1, 1, 1};

    rst          = 1'b1;
    start_signal = 1'b0;
    mode_avg     = 1'b0;
    pixel_valid  = 1'b0;
    pixel_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_result_out", int'(result_out != '0), 0);
    checkValue("reset_result_valid", int'(result_valid), 0);
    checkValue("reset_busy", int'(busy), 0);
    checkValue("reset_done", int'(done_signal), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // IDLE ignores pixel_valid.
    pixel_valid = 1'b1;
    pixel_in    = {DW'(99), DW'(99)};
    repeat (3) @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    checkValue("idle_busy", int'(busy), 0);

    $display("[TB] test 1: max, ramp");
    rampPixels();
    pushFrame(maxE0, maxE1);
    startFrame(1'b0);
    applyStimulus(16, 0, 1'b0);
    // This cycle carries done; a start here must be ignored.
    start_signal = 1'b1;
    @(posedge clk); #1;
    start_signal = 1'b0;
    checkValue("start_in_done_cycle", int'(busy), 0);
    drain();
    checkValue("result_hold", int'($signed(result_out[DW-1:0])), relu(16));

    $display("[TB] test 2: avg, ramp");
    pushFrame(avgE0, avgE1);
    startFrame(1'b1);
    applyStimulus(16, 0, 1'b0);
    drain();

    $display("[TB] test 3: avg, alternating negative rows");
    for (int i = 0; i < 16; i++) begin
      pix0[i] = ((i / 4) % 2 == 0) ? -1 : -2;
      pix1[i] = -pix0[i];
    end
    pushFrame(altE0, altE1);
    startFrame(1'b1);
    applyStimulus(16, 0, 1'b0);
    drain();

    $display("[TB] test 5: max with gaps and mid-frame start");
    rampPixels();
    pushFrame(maxE0, maxE1);
    startFrame(1'b0);
    applyStimulus(16, 3, 1'b1);
    drain();

    $display("[TB] test 6: reset mid-frame then full frame");
    expQ.push_back('{l0: relu(6), l1: relu(-1), done: 1'b0});
    startFrame(1'b0);
    applyStimulus(7, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkValue("abort_busy", int'(busy), 0);
    checkValue("abort_result_out", int'(result_out != '0), 0);
    checkValue("abort_queue", expQ.size(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    pushFrame(maxE0, maxE1);
    startFrame(1'b0);
    applyStimulus(16, 0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
